// File: rtl/mem_access_unit_if.sv
// Load/store request, response and data-memory port bundle for mem_access_unit.
// The slave side is the access unit; the master side is the pipeline plus memory.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_read, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output stall, load_data, load_valid, misaligned,
        output mem_MemRead, mem_MemWrite, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_read, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  stall, load_data, load_valid, misaligned,
        input  mem_MemRead, mem_MemWrite, mem_address, mem_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS byte/half/word load-store unit over a word-wide memory (big-endian lanes).
// Sub-word stores are read-modify-write across two cycles with one stall cycle.
module mem_access_unit (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic {S_IDLE = 1'b0, S_RMW_WRITE = 1'b1} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_merge, r_load_data;
    logic        r_load_valid, r_misaligned;
    logic        w_store, w_load, w_misal, w_sub, w_load_ok;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext, w_merged;

    assign w_off   = bus.req_addr[1:0];
    assign w_store = bus.req_valid & bus.req_write;
    assign w_load  = bus.req_valid & bus.req_read & ~bus.req_write;
    assign w_misal = bus.req_size[1] ? (w_off != 2'b00) :
                     (bus.req_size[0] ? w_off[0] : 1'b0);
    assign w_sub   = w_store & ~w_misal & ~bus.req_size[1];

    // Big-endian: offset k lives at bit 8*(3-k), and 3-k == ~k for two bits.
    assign w_byte = bus.mem_read_data[{~w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];

    always_comb begin
        w_merged = bus.mem_read_data;
        if (bus.req_size[0])
            w_merged[{~w_off[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
        else
            w_merged[{~w_off, 3'b000} +: 8] = bus.req_wdata[7:0];
    end

    always_comb begin
        case (bus.req_size)
            2'b00:   w_ext = bus.req_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ext = bus.req_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ext = bus.mem_read_data;
        endcase
    end

    always_comb begin
        w_next             = r_state;
        w_load_ok          = 1'b0;
        bus.stall          = 1'b0;
        bus.mem_MemRead    = 1'b0;
        bus.mem_MemWrite   = 1'b0;
        bus.mem_write_data = bus.req_wdata;
        case (r_state)
            S_IDLE: begin
                if (!w_misal) begin
                    if (w_load) begin
                        bus.mem_MemRead = 1'b1;
                        w_load_ok       = 1'b1;
                    end else if (w_sub) begin
                        bus.mem_MemRead = 1'b1;
                        bus.stall       = 1'b1;
                        w_next          = S_RMW_WRITE;
                    end else if (w_store) begin
                        bus.mem_MemWrite = 1'b1;
                    end
                end
            end
            S_RMW_WRITE: begin
                bus.mem_MemWrite   = 1'b1;
                bus.mem_write_data = r_merge;
                w_next             = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // While reset is held nothing may reach memory, even a pending RMW write.
        if (!rst_n) begin
            bus.stall        = 1'b0;
            bus.mem_MemRead  = 1'b0;
            bus.mem_MemWrite = 1'b0;
        end
    end

    assign bus.mem_address = {bus.req_addr[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_merge      <= 32'b0;
            r_load_data  <= 32'b0;
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_load_ok) begin
                    r_load_data  <= w_ext;
                    r_load_valid <= 1'b1;
                end
                if ((w_load | w_store) & w_misal)
                    r_misaligned <= 1'b1;
                if (w_sub)
                    r_merge <= w_merged;
            end
        end
    end

    assign bus.load_data  = r_load_data;
    assign bus.load_valid = r_load_valid;
    assign bus.misaligned = r_misaligned;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit sitting between the EX/MEM pipeline register and the word-wide `data_memory`. Converts MIPS byte, halfword and word loads/stores into word accesses. Sub-word loads are extracted and sign/zero-extended. Sub-word stores are performed as a two-cycle read-modify-write with a pipeline stall, and misaligned accesses are flagged instead of issued.

## Interface
- No parameters. Data and address width fixed at 32.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  memory operation present in MEM stage.
- `req_read`  in  1  load.
- `req_write`  in  1  store; has priority over `req_read` if both set.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `req_unsigned`  in  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `stall`  out  1  hold EX/MEM and upstream stages; request must stay stable while high.
- `load_data`  out  32  registered extended load result.
- `load_valid`  out  1  registered, 1-cycle pulse with `load_data`.
- `misaligned`  out  1  registered, 1-cycle pulse on alignment fault.
- `mem_MemRead`  out  1  to `data_memory.MemRead`.
- `mem_MemWrite`  out  1  to `data_memory.MemWrite`.
- `mem_address`  out  32  word address `{req_addr[31:2],2'b00}`.
- `mem_write_data`  out  32  to `data_memory.write_data`.
- `mem_read_data`  in  32  from `data_memory.read_data`, combinational read of `mem_address`.

## Operation
- Big-endian lanes. `addr[1:0]`=0 selects bits [31:24], and 3 selects [7:0]. Halfword at offset 0 is [31:16], at offset 2 is [15:0].
- Alignment:
  - Half requires `addr[0]`=0.
  - Word requires `addr[1:0]`=0.
  - On a fault, the memory strobes stay 0, `misaligned` pulses the next cycle, `load_valid` stays 0, and there is no stall.
- FSM states:
  - IDLE.
  - RMW_WRITE. Entered only from IDLE on an aligned sub-word store.
- In IDLE:
  - **Load:** `mem_MemRead`=1. The lane is extracted from `mem_read_data`, extended, and registered into `load_data`; `load_valid`=1 the next cycle. `stall`=0.
  - **Word store:** `mem_MemWrite`=1, `mem_write_data`=`req_wdata`, same cycle. `stall`=0.
  - **Sub-word store:** `mem_MemRead`=1, `stall`=1. The merged word (the `mem_read_data` word with the target lane replaced by `req_wdata` low bits) is captured into an internal register. Transition to RMW_WRITE.
  - **No valid request:** all `mem_*` strobes are 0, and `mem_address`/`mem_write_data` are don't-care.
- In RMW_WRITE:
  - `mem_MemWrite`=1 and `mem_write_data`=merged register.
  - `stall`=0, so the pipeline advances at the closing edge.
  - Return to IDLE unconditionally.
- `req_valid`=0 with `req_read`/`req_write` set: no access.
- Reset (any time, including in RMW_WRITE):
  - State returns to IDLE and the pending write is dropped; no partial store reaches memory.
  - Outputs: `load_data`=0, `load_valid`=0, `misaligned`=0, `stall`=0, all `mem_*` strobes 0.

## Timing
- Load latency: address presented cycle N, `load_data`/`load_valid` valid after edge N+1.
- Word store: committed at edge ending cycle N.
- Sub-word store:
  - Read in cycle N with `stall`=1.
  - Write in cycle N+1; committed at edge ending N+1.
  - Exactly one stall cycle per sub-word store.
- Back-to-back sub-word stores: each takes 2 cycles. A load immediately after a sub-word store to the same word returns the merged value.
- `stall` and `mem_*` are combinational from state and request. `load_data`, `load_valid` and `misaligned` are registered.
- `load_valid` and `misaligned` are never high in the same cycle.

## Test plan
- **Word load:** sw 0xDEADBEEF @0, lw @0 → `load_data`=0xDEADBEEF, `load_valid` one cycle later.
- **Byte/half loads:** memory @0=0xDEADBEEF.
  - lb @0 → 0xFFFFFFDE.
  - lbu @1 → 0x000000AD.
  - lh @2 → 0xFFFFBEEF.
  - lhu @0 → 0x0000DEAD.
- **Sub-word stores:** memory @4=0xCAFEBABE.
  - sb 0x11 @6 → `stall` high 1 cycle, then lw @4 = 0xCAFE11BE.
  - sh 0x2233 @4 → then lw @4 = 0x223311BE.
- **Misaligned accesses:** lw @2, sh @1, sw @3 → `misaligned` pulses, memory @0..@7 unchanged, no `load_valid`, no stall.
- **Reset during RMW:** sb 0x55 @8 (memory @8=0); assert `rst_n`=0 during RMW_WRITE → lw @8 after reset = 0x00000000, all outputs at reset values.
- **Simultaneous read/write:** `req_read`=`req_write`=1, word @12, data 0x12345678 → store performed, no `load_valid`; lw @12 = 0x12345678.
